// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control unit: encodings,
// the per-stage control record and small hazard helpers.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       use_rs;
        logic       use_rt;
        logic       we;
        logic       load;
        alu_op_t    op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
    } stage_ctl_t;

    // A stage only counts as a producer when it is live and actually writes.
    function automatic logic writes_reg(input stage_ctl_t s, input logic [4:0] r);
        return s.valid && s.we && (s.dest == r);
    endfunction

    function automatic fwd_sel_t fwd_pick(input stage_ctl_t mem_s, input stage_ctl_t wb_s,
                                          input logic use_r, input logic [4:0] r);
        if (use_r && writes_reg(mem_s, r) && !mem_s.load)
            return FWD_MEM;
        if (use_r && writes_reg(wb_s, r))
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_decode.sv
// Combinational decode of the instruction held in ID into a stage control record.
module pipe_decode
    import pipe_pkg::*;
(
    input  logic        id_valid,
    input  logic [31:0] id_ins,
    output stage_ctl_t  ctl
);

    logic unused_shamt;
    assign unused_shamt = ^id_ins[10:6];

    always_comb begin
        ctl = '0;
        if (id_valid) begin
            ctl.valid = 1'b1;
            ctl.rs    = id_ins[25:21];
            ctl.rt    = id_ins[20:16];
            ctl.op    = ALU_ADD;
            case (id_ins[31:26])
                OP_RTYPE: begin
                    ctl.use_rs = 1'b1;
                    ctl.use_rt = 1'b1;
                    ctl.dest   = id_ins[15:11];
                    ctl.we     = 1'b1;
                    case (id_ins[5:0])
                        FN_AND:  ctl.op = ALU_AND;
                        FN_OR:   ctl.op = ALU_OR;
                        FN_ADD:  ctl.op = ALU_ADD;
                        FN_SUB:  ctl.op = ALU_SUB;
                        FN_SLT:  ctl.op = ALU_SLT;
                        default: ctl.we = 1'b0;
                    endcase
                end
                OP_LW: begin
                    ctl.use_rs   = 1'b1;
                    ctl.dest     = id_ins[20:16];
                    ctl.we       = 1'b1;
                    ctl.load     = 1'b1;
                    ctl.alu_src  = 1'b1;
                    ctl.mem_read = 1'b1;
                end
                OP_SW: begin
                    ctl.use_rs    = 1'b1;
                    ctl.use_rt    = 1'b1;
                    ctl.alu_src   = 1'b1;
                    ctl.mem_write = 1'b1;
                end
                OP_BEQ: begin
                    ctl.use_rs = 1'b1;
                    ctl.use_rt = 1'b1;
                    ctl.op     = ALU_SUB;
                end
                OP_J:    ;
                default: ;
            endcase
            // $0 is hardwired, so writing it must never look like a producer.
            if (ctl.dest == 5'd0)
                ctl.we = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctl.sv
// Pipeline control unit: carries decoded control through EX/MEM/WB and drives
// stall, flush, interrupt entry, forwarding selects and event counters.
module pipe_ctl
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_req,
    input  logic              id_valid,
    input  logic [31:0]       id_ins,
    input  logic              ex_taken,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              pc_sel_entry,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic [2:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_we,
    output logic              wb_mem2reg,
    output logic [REG_AW-1:0] wb_rd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    stage_ctl_t id_ctl, ex_q, mem_q, wb_q;
    logic       stall_req, stall_evt, flush_evt;

    pipe_decode u_decode (
        .id_valid (id_valid),
        .id_ins   (id_ins),
        .ctl      (id_ctl)
    );

    // Stall detection; bubbles in ID have no used sources so never stall.
    always_comb begin
        stall_req = 1'b0;
        if (FWD_EN) begin
            stall_req = ex_q.load &&
                        ((id_ctl.use_rs && writes_reg(ex_q, id_ctl.rs)) ||
                         (id_ctl.use_rt && writes_reg(ex_q, id_ctl.rt)));
        end else begin
            stall_req = (id_ctl.use_rs && (writes_reg(ex_q, id_ctl.rs) || writes_reg(mem_q, id_ctl.rs))) ||
                        (id_ctl.use_rt && (writes_reg(ex_q, id_ctl.rt) || writes_reg(mem_q, id_ctl.rt)));
        end
    end

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        pc_sel_entry = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;
        if (rst) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (int_req) begin
            pc_sel_entry = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            flush_evt    = 1'b1;
        end else if (ex_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
        end else if (stall_req) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            stall_evt  = 1'b1;
        end
    end

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN) begin
            fwd_a = fwd_pick(mem_q, wb_q, ex_q.use_rs, ex_q.rs);
            fwd_b = fwd_pick(mem_q, wb_q, ex_q.use_rt, ex_q.rt);
        end
    end

    // The instruction in MEM is squashed on interrupt entry: no memory side effect.
    assign ex_alu_op  = ex_q.valid ? ex_q.op : 3'b000;
    assign ex_alu_src = ex_q.valid && ex_q.alu_src;
    assign mem_read   = mem_q.valid && mem_q.mem_read && !int_req;
    assign mem_write  = mem_q.valid && mem_q.mem_write && !int_req;
    assign wb_we      = wb_q.valid && wb_q.we;
    assign wb_mem2reg = wb_q.valid && wb_q.load;
    assign wb_rd      = wb_q.valid ? REG_AW'(wb_q.dest) : '0;

    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb_q.rs, wb_q.rt, wb_q.use_rs, wb_q.use_rt, wb_q.op,
                              wb_q.alu_src, wb_q.mem_read, wb_q.mem_write};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= idex_flush  ? '0 : id_ctl;
            mem_q <= exmem_flush ? '0 : ex_q;
            wb_q  <= int_req     ? '0 : mem_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
